// File: rtl/eth_pcs_rx_ber_monitor_if.sv
// Bus between the RX gearbox/block-sync side and the high-BER monitor.
// Optional statistics signals exist only when ETH_PCS_RX_BER_STATS_EN is defined.
interface eth_pcs_rx_ber_monitor_if #(
  parameter int W_SYNC = 2
);
  logic              i_rx_lock;
  logic              i_hdr_valid;
  logic [W_SYNC-1:0] i_hdr;
  logic              o_hi_ber;
  logic              o_rx_status;
  logic              o_win_active;
`ifdef ETH_PCS_RX_BER_STATS_EN
  logic              i_stat_clr;
  logic [21:0]       o_ber_errs;

  modport master (
    output i_rx_lock, i_hdr_valid, i_hdr, i_stat_clr,
    input  o_hi_ber, o_rx_status, o_win_active, o_ber_errs
  );
  modport slave (
    input  i_rx_lock, i_hdr_valid, i_hdr, i_stat_clr,
    output o_hi_ber, o_rx_status, o_win_active, o_ber_errs
  );
`else
  modport master (
    output i_rx_lock, i_hdr_valid, i_hdr,
    input  o_hi_ber, o_rx_status, o_win_active
  );
  modport slave (
    input  i_rx_lock, i_hdr_valid, i_hdr,
    output o_hi_ber, o_rx_status, o_win_active
  );
`endif
endinterface

// File: rtl/eth_pcs_rx_ber_monitor.sv
// 10GBASE-R high-BER monitor: counts invalid sync headers per timer window.
// Optional ETH_PCS_RX_BER_STATS_EN adds a saturating invalid-header counter.
module eth_pcs_rx_ber_monitor #(
  parameter int W_SYNC       = 2,
  parameter int TIMER_CYCLES = 40283,
  parameter int BER_THRESH   = 16,
  parameter int W_BER_CNT    = 6
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  eth_pcs_rx_ber_monitor_if.slave   bus,
  output logic [1:0]                o_dbg_state
);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_TEST   = 2'd1,
    ST_HI_BER = 2'd2
  } state_t;

  localparam int W_TMR = (TIMER_CYCLES > 2) ? $clog2(TIMER_CYCLES) : 1;
  localparam logic [W_TMR-1:0]     TMR_LOAD = W_TMR'(TIMER_CYCLES - 1);
  localparam logic [W_BER_CNT-1:0] THRESH   = W_BER_CNT'(BER_THRESH);

  state_t               state_q, state_d;
  logic [W_TMR-1:0]     timer_q, timer_d;
  logic [W_BER_CNT-1:0] cnt_q, cnt_d;
  logic                 hi_ber_q, hi_ber_d;

  logic                 hdr_bad;
  logic [W_BER_CNT-1:0] cnt_inc;
  logic                 tmr_zero;
  logic [W_TMR-1:0]     tmr_next;

  assign hdr_bad  = bus.i_hdr_valid &&
                    ((bus.i_hdr == {W_SYNC{1'b0}}) || (bus.i_hdr == {W_SYNC{1'b1}}));
  assign cnt_inc  = (hdr_bad && (cnt_q != {W_BER_CNT{1'b1}})) ? cnt_q + 1'b1 : cnt_q;
  assign tmr_zero = (timer_q == '0);
  assign tmr_next = tmr_zero ? TMR_LOAD : timer_q - 1'b1;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    cnt_d    = cnt_q;
    hi_ber_d = hi_ber_q;
    if (!bus.i_rx_lock) begin
      state_d  = ST_INIT;
      timer_d  = '0;
      cnt_d    = '0;
      hi_ber_d = 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          hi_ber_d = 1'b0;
          cnt_d    = '0;
          timer_d  = TMR_LOAD;
          state_d  = ST_TEST;
        end
        ST_TEST: begin
          timer_d = tmr_next;
          if (hdr_bad && (cnt_inc == THRESH)) begin
            hi_ber_d = 1'b1;
            state_d  = ST_HI_BER;
            // Threshold on the window's last cycle starts a fresh, empty window.
            cnt_d    = tmr_zero ? '0 : cnt_inc;
          end else if (tmr_zero) begin
            hi_ber_d = 1'b0;
            cnt_d    = '0;
          end else begin
            cnt_d    = cnt_inc;
          end
        end
        ST_HI_BER: begin
          timer_d = tmr_next;
          if (tmr_zero) begin
            // Still at threshold means this is the window that tripped; a
            // window that began in HI_BER ends clean and releases hi_ber.
            hi_ber_d = (cnt_q >= THRESH);
            cnt_d    = '0;
            state_d  = ST_TEST;
          end
        end
        default: begin
          state_d  = ST_INIT;
          timer_d  = '0;
          cnt_d    = '0;
          hi_ber_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= ST_INIT;
      timer_q  <= '0;
      cnt_q    <= '0;
      hi_ber_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      cnt_q    <= cnt_d;
      hi_ber_q <= hi_ber_d;
    end
  end

  assign bus.o_hi_ber     = hi_ber_q;
  assign bus.o_rx_status  = bus.i_rx_lock & ~hi_ber_q;
  assign bus.o_win_active = (state_q == ST_TEST) || (state_q == ST_HI_BER);
  assign o_dbg_state      = state_q;

`ifdef ETH_PCS_RX_BER_STATS_EN
  logic [21:0] errs_q, errs_d;

  always_comb begin
    errs_d = errs_q;
    if (bus.i_stat_clr) begin
      errs_d = '0;
    end else if (bus.i_rx_lock && hdr_bad && (errs_q != {22{1'b1}})) begin
      errs_d = errs_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      errs_q <= '0;
    end else begin
      errs_q <= errs_d;
    end
  end

  assign bus.o_ber_errs = errs_q;
`endif

endmodule

// File: tb/tb_eth_pcs_rx_ber_monitor.sv
// Directed bench for eth_pcs_rx_ber_monitor with a 64-clock BER window.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_eth_pcs_rx_ber_monitor;

  localparam int TC = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  eth_pcs_rx_ber_monitor_if #(.W_SYNC(2)) bus ();

  eth_pcs_rx_ber_monitor #(
    .W_SYNC       (2),
    .TIMER_CYCLES (TC),
    .BER_THRESH   (16),
    .W_BER_CNT    (6)
  ) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  int         n_checks = 0;
  int         n_errs   = 0;
  logic       hb [0:TC-1];
  logic [0:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of inputs, clocks once, returns at the next falling edge.
  task automatic step(input logic lock, input logic hv, input logic bad);
    bus.i_rx_lock   = lock;
    bus.i_hdr_valid = hv;
    if (!hv)      bus.i_hdr = 2'($urandom_range(0, 3));
    else if (bad) bus.i_hdr = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
    else          bus.i_hdr = 2'($urandom_range(1, 2));
    @(posedge clk);
    @(negedge clk);
  endtask

  // One full window: headers on even cycles, the first nbad of them invalid,
  // plus an optional invalid header on the timer-0 cycle.
  task automatic run_window(input int nbad, input logic last_bad);
    for (int s = 0; s < TC; s++) begin
      logic hv, bad;
      hv  = ((s % 2) == 0) || ((s == TC - 1) && last_bad);
      bad = (((s % 2) == 0) && (s < 2 * nbad)) || ((s == TC - 1) && last_bad);
      step(1'b1, hv, bad);
      hb[s] = bus.o_hi_ber;
    end
  endtask

  function automatic logic any_hb();
    logic r;
    r = 1'b0;
    for (int s = 0; s < TC; s++) r |= hb[s];
    return r;
  endfunction

  task automatic check_win_end(input string tag);
    if (exp_q.size() == 0) begin
      check({tag, "_noexp"}, 32'd1, 32'd0);
    end else begin
      check(tag, 32'(hb[TC-1]), 32'(exp_q.pop_front()));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n           = 1'b0;
    bus.i_rx_lock   = 1'b0;
    bus.i_hdr_valid = 1'b0;
    bus.i_hdr       = 2'b00;
`ifdef ETH_PCS_RX_BER_STATS_EN
    bus.i_stat_clr  = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_hi_ber",     32'(bus.o_hi_ber),     32'd0);
    check("rst_win_active", 32'(bus.o_win_active), 32'd0);
    check("rst_state",      32'(dbg_state),        32'd0);
    check("rst_rx_status",  32'(bus.o_rx_status),  32'd0);
    rst_n = 1'b1;

    step(1'b0, 1'b0, 1'b0);
    check("unlocked_win_active", 32'(bus.o_win_active), 32'd0);
    step(1'b1, 1'b0, 1'b0);
    check("lock_win_active", 32'(bus.o_win_active), 32'd1);
    check("lock_state",      32'(dbg_state),        32'd1);
    check("lock_rx_status",  32'(bus.o_rx_status),  32'd1);

    // Ten clean windows.
    for (int w = 0; w < 10; w++) exp_q.push_back(1'b0);
    for (int w = 0; w < 10; w++) begin
      run_window(0, 1'b0);
      check("t1_any_hi_ber", 32'(any_hb()), 32'd0);
      check_win_end("t1_win_end");
    end
    check("t1_rx_status",  32'(bus.o_rx_status),  32'd1);
    check("t1_win_active", 32'(bus.o_win_active), 32'd1);

    // Sixteen bad headers, then a clean window.
    run_window(16, 1'b0);
    check("t2_after_15",   32'(hb[28]),    32'd0);
    check("t2_after_16",   32'(hb[30]),    32'd1);
    check("t2_trip_end",   32'(hb[TC-1]),  32'd1);
    check("t2_state_test", 32'(dbg_state), 32'd1);
    run_window(0, 1'b0);
    check("t2_clean_hold", 32'(hb[TC-2]),  32'd1);
    check("t2_clean_fall", 32'(hb[TC-1]),  32'd0);

    // Fifteen bad headers per window never trip.
    for (int w = 0; w < 3; w++) exp_q.push_back(1'b0);
    for (int w = 0; w < 3; w++) begin
      run_window(15, 1'b0);
      check("t3_any_hi_ber", 32'(any_hb()), 32'd0);
      check_win_end("t3_win_end");
    end

    // Sixteenth bad header lands on the timer-0 cycle.
    run_window(15, 1'b1);
    check("t4_before_last", 32'(hb[TC-2]),  32'd0);
    check("t4_on_last",     32'(hb[TC-1]),  32'd1);
    check("t4_state_hiber", 32'(dbg_state), 32'd2);
    run_window(0, 1'b0);
    check("t4_hold", 32'(hb[TC-2]), 32'd1);
    check("t4_fall", 32'(hb[TC-1]), 32'd0);

    // Lock drop while in HI_BER.
    for (int s = 0; s < 40; s++) step(1'b1, (s % 2) == 0, ((s % 2) == 0) && (s < 32));
    check("t5_in_hi_ber", 32'(bus.o_hi_ber), 32'd1);
    check("t5_state",     32'(dbg_state),    32'd2);
    bus.i_rx_lock = 1'b0;
    #1;
    check("t5_status_drop", 32'(bus.o_rx_status), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    check("t5_hi_ber_drop",  32'(bus.o_hi_ber),     32'd0);
    check("t5_win_inactive", 32'(bus.o_win_active), 32'd0);
    step(1'b1, 1'b0, 1'b0);
    check("t5_relock_active", 32'(bus.o_win_active), 32'd1);
    check("t5_relock_status", 32'(bus.o_rx_status),  32'd1);
    run_window(16, 1'b0);
    check("t5_cnt0_after_15", 32'(hb[28]), 32'd0);
    check("t5_cnt0_after_16", 32'(hb[30]), 32'd1);

`ifdef ETH_PCS_RX_BER_STATS_EN
    bus.i_stat_clr = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    bus.i_stat_clr = 1'b0;
    check("st_cleared", 32'(bus.o_ber_errs), 32'd0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b0);
    end
    check("st_twenty", 32'(bus.o_ber_errs), 32'd20);
    bus.i_stat_clr = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    bus.i_stat_clr = 1'b0;
    check("st_clr_with_bad", 32'(bus.o_ber_errs), 32'd0);
    force dut.errs_q = 22'h3FFFFF;
    step(1'b1, 1'b0, 1'b0);
    release dut.errs_q;
    step(1'b1, 1'b1, 1'b1);
    check("st_saturate", 32'(bus.o_ber_errs), 32'h3FFFFF);
`endif

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/eth_pcs_rx_ber_monitor.md
Name: eth_pcs_rx_ber_monitor

Overview:
Clause-49 high-BER monitor for the 10GBASE-R receive path. It sits beside the RX gearbox and block-sync pair and consumes the gearbox's sync-header strobe plus the block-lock indication. It counts invalid sync headers inside fixed 125 us windows and raises o_hi_ber when the count reaches the threshold. It also produces o_rx_status, which the RX decoder and link logic use to gate the datapath.

Parameters:
W_SYNC, 2, sync header width
TIMER_CYCLES, 40283, clocks per BER window (125 us at 322.27 MHz); legal range 2..2^20
BER_THRESH, 16, bad-header count within one window that declares hi_ber; 1..63
W_BER_CNT, 6, width of the in-window bad-header counter; must hold BER_THRESH

Ports:
i_clk  in  1  core clock, shared with the RX gearbox
i_reset_n  in  1  asynchronous, active-low reset
i_rx_lock  in  1  block lock from block sync
i_hdr_valid  in  1  one-cycle strobe; i_hdr is valid this cycle
i_hdr  in  W_SYNC  sync header, bit order as emitted by the gearbox
o_hi_ber  out  1  high bit-error-rate declared
o_rx_status  out  1  i_rx_lock & ~o_hi_ber (combinational from registered o_hi_ber)
o_win_active  out  1  a BER window is running (state TEST or HI_BER)

Behaviour:
- Reset (async assert, sync deassert by the integrator): state INIT, window counter 0, timer 0, o_hi_ber 0, o_win_active 0.
- Valid header: 2'b01 or 2'b10. Invalid header: 2'b00 or 2'b11. Headers are sampled only when i_hdr_valid is 1.
- States:
  - INIT: o_hi_ber <= 0, count <= 0. If i_rx_lock=1, load timer with TIMER_CYCLES-1, go to TEST. No header is counted in the transition cycle.
  - TEST: timer decrements every clock.
    - Invalid header increments count, saturating at 2^W_BER_CNT-1.
    - If the post-increment count equals BER_THRESH: o_hi_ber <= 1, go to HI_BER. The timer keeps running.
    - Otherwise, when the timer is 0 (window end): o_hi_ber <= 0, count <= 0, reload timer, stay in TEST.
  - HI_BER: headers are ignored and the timer decrements. At timer 0: count <= 0, reload timer, go to TEST. o_hi_ber stays 1 until a later window completes with count < BER_THRESH.
- Simultaneous invalid header and timer 0 in TEST: the header counts in the expiring window.
  - If this reaches BER_THRESH: o_hi_ber <= 1, reload timer, go to HI_BER with a fresh window.
  - Else: normal window end.
- i_rx_lock=0 in any state has priority over everything: next state INIT, o_hi_ber <= 0, count 0. Lock may drop mid-window; a partial window is discarded.
- Latency: o_hi_ber rises 1 clock after the cycle carrying the BER_THRESH-th invalid header. It falls 1 clock after the clean window's timer-0 cycle. o_rx_status follows o_hi_ber combinationally and follows i_rx_lock combinationally.
- A window spans exactly TIMER_CYCLES clocks: from the cycle after the load to the timer-0 cycle inclusive.
- The timer is wide enough for TIMER_CYCLES-1. Arithmetic is unsigned with no wrap.

Optional Feature:
Macro ETH_PCS_RX_BER_STATS_EN.
- Defined: adds ports i_stat_clr (in, 1) and o_ber_errs (out, 22). o_ber_errs counts every invalid header seen while i_rx_lock=1 in any state, including HI_BER. It saturates at 2^22-1, resets to 0, and is cleared synchronously by i_stat_clr. A clear in the same cycle as an invalid header yields 0.
- Undefined: these ports and the counter do not exist, and the core behaviour is identical.

Test Plan:
- TIMER_CYCLES=64, lock=1, headers every 2 clocks all 2'b01 for 10 windows -> o_hi_ber stays 0, o_rx_status=1, o_win_active=1 from 1 clock after lock.
- 16 headers of 2'b00 within one window -> o_hi_ber=1 exactly 1 clock after the 16th; next window with 0 bad headers -> o_hi_ber falls 1 clock after that window's timer-0 cycle.
- 15 bad headers in each of 3 consecutive windows -> o_hi_ber never asserts; the count clears at each window end.
- 15 bad headers, then the 16th on the timer-0 cycle -> o_hi_ber=1 and a fresh window starts; exactly 64 clocks later with clean headers -> o_hi_ber=0.
- Drop i_rx_lock for 1 clock while in HI_BER -> o_hi_ber=0 and o_rx_status=0 that cycle; after relock, a new window starts and the count begins at 0.
- With ETH_PCS_RX_BER_STATS_EN: 20 bad headers -> o_ber_errs=20; assert i_stat_clr together with a bad header -> 0; force the counter to 2^22-1 and add a bad header -> it holds at 2^22-1.
